// File: rtl/carry_save_resolver_if.sv
`default_nettype none
// ============================================================================
// Module   : carry_save_resolver_if
// Purpose  : Handshake/data bundle between a carry-save producer, the
//            carry_save_resolver and the downstream consumer of its result.
// Signals  : in_valid/in_ready   - input handshake for a (sum, carry) pair
//            sum[N-1:0]          - carry-save sum vector, bit i weight 2^i
//            carry[N-1:0]        - carry-save carry vector, bit i weight 2^(i+1)
//            out_valid/out_ready - output handshake for result
//            result[N+1:0]       - binary value of sum + 2*carry
//            busy                - resolver is stepping through chunks
// Modports : master - upstream/downstream side, slave - resolver side
// Revision : 1.0 - initial release
// ============================================================================
interface carry_save_resolver_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] sum;
  logic [N-1:0] carry;
  logic         out_valid;
  logic         out_ready;
  logic [N+1:0] result;
  logic         busy;

  modport master (
    output in_valid, sum, carry, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, sum, carry, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface
`default_nettype wire

// File: rtl/carry_save_resolver.sv
`default_nettype none
// ============================================================================
// Module   : carry_save_resolver
// Purpose  : Resolves a carry-save (sum, carry) pair into a plain binary value
//            with a chunk-serial carry-propagate add, W bits per clock.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - carry_save_resolver_if.slave (handshakes, data, busy)
// Params   : N - width of sum/carry; W - chunk width, 1 <= W <= N+2
// Timing   : out_valid rises C = ceil((N+2)/W) clocks after the accepting
//            edge; one operation per C+2 clocks at best.
// Revision : 1.0 - initial release
// ============================================================================
module carry_save_resolver #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  carry_save_resolver_if.slave bus
);

  localparam int C_CHUNKS = (N + 2 + W - 1) / W;
  localparam int C_M      = C_CHUNKS * W;
  localparam int C_IW     = (C_CHUNKS > 1) ? $clog2(C_CHUNKS) : 1;
  localparam logic [C_IW-1:0] C_LAST = C_IW'(C_CHUNKS - 1);

  generate
    if (N < 1 || W < 1 || W > N + 2) begin : g_bad_params
      $error("carry_save_resolver: parameters out of range (N=%0d W=%0d)", N, W);
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [C_M-1:0]  r_x;
  logic [C_M-1:0]  r_y;
  logic [C_M-1:0]  r_res;
  logic [C_IW-1:0] r_idx;
  logic            r_cin;

  logic [31:0]     w_base;
  logic [W:0]      w_chunk;
  logic            w_capture;
  logic            w_last;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        bus.busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_capture = (r_state == S_IDLE) && bus.in_valid;
  assign w_last    = (r_idx == C_LAST);

  // One W-bit slice of the carry-propagate add; bit W is the chunk carry-out.
  assign w_base  = 32'(r_idx) * 32'(W);
  assign w_chunk = {1'b0, r_x[w_base +: W]} + {1'b0, r_y[w_base +: W]} +
                   {{W{1'b0}}, r_cin};

  // ---------------------------------------------------------------------------
  // Datapath: operand capture and chunk-by-chunk resolve
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_res <= '0;
      r_idx <= '0;
      r_cin <= 1'b0;
    end else if (w_capture) begin
      r_x   <= C_M'(bus.sum);
      r_y   <= C_M'({bus.carry, 1'b0});
      r_res <= '0;
      r_idx <= '0;
      r_cin <= 1'b0;
    end else if (r_state == S_BUSY) begin
      r_res[w_base +: W] <= w_chunk[W-1:0];
      r_cin              <= w_chunk[W];
      // Park the index at zero after the last chunk so it never points past
      // the operand registers.
      r_idx              <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  // The sum of two N+1 bit values never reaches bit N+2, so the padding bits
  // of the internal result are dropped.
  assign bus.result = r_res[N+1:0];

  generate
    if (C_M > N + 2) begin : g_pad_sink
      logic w_unused_pad;
      assign w_unused_pad = ^r_res[C_M-1:N+2];
    end
  endgenerate

endmodule
`default_nettype wire
